// File: rtl/serial_to_par_rx_if.sv
// Byte-lane bundle between a serial transmitter and the serial_to_par_rx receiver.
// The master side owns the serial bit; the slave (receiver) owns the recovered byte outputs.
interface serial_to_par_rx_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       byte_strobe;

   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  byte_strobe
   );

   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output active,
      output byte_strobe
   );
endinterface

// File: rtl/serial_to_par_rx.sv
// Serial-to-parallel receiver with comma-based byte alignment.
// A comma symbol found at any bit offset starts alignment. LOCK_COUNT consecutive
// commas on 8-bit boundaries declare lock. Once locked, the receiver stays locked
// until reset and delivers each non-comma byte with zero latency after its last bit.
module serial_to_par_rx #(
   parameter logic [7:0] COMMA      = 8'hBC,
   parameter int         LOCK_COUNT = 4
) (
   input  logic              clk_8f,
   input  logic              reset_L,
   serial_to_par_rx_if.slave bus
);

   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] ALIGN  = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);

   // Comma count never wraps: it sticks at the lock threshold.
   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      if (cnt >= LOCK_C) begin
         sat_inc = LOCK_C;
      end else begin
         sat_inc = cnt + 4'd1;
      end
   endfunction

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [7:0] sr;
   logic [7:0] cand;
   logic [2:0] bit_cnt;
   logic [2:0] bit_cnt_nxt;
   logic [3:0] comma_cnt;
   logic [3:0] comma_cnt_nxt;
   logic       cand_is_comma;
   logic       byte_done;
   logic       strobe_nxt;
   logic       load_data;
   logic       clr_valid;

   logic [7:0] data_out_r;
   logic       valid_out_r;
   logic       active_r;
   logic       byte_strobe_r;

   // The byte as it will look after this edge's bit is shifted in.
   assign cand          = {sr[6:0], bus.data_in};
   assign cand_is_comma = (cand == COMMA);
   // Byte boundaries only exist once a comma has fixed the bit phase.
   assign byte_done     = (state != SEARCH) && (bit_cnt == 3'd7);

   // Next-state and per-byte decisions for the alignment FSM.
   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      comma_cnt_nxt = comma_cnt;
      strobe_nxt    = 1'b0;
      load_data     = 1'b0;
      clr_valid     = 1'b0;

      case (state)
         SEARCH: begin
            bit_cnt_nxt = 3'd0;
            if (cand_is_comma) begin
               comma_cnt_nxt = 4'd1;
               state_nxt     = (LOCK_C <= 4'd1) ? ACTIVE : ALIGN;
            end
         end

         ALIGN: begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (byte_done) begin
               if (cand_is_comma) begin
                  comma_cnt_nxt = sat_inc(comma_cnt);
                  if (sat_inc(comma_cnt) >= LOCK_C) begin
                     state_nxt = ACTIVE;
                  end
               end else begin
                  // Broken comma run: restart the hunt, but this edge is not a new match.
                  comma_cnt_nxt = 4'd0;
                  bit_cnt_nxt   = 3'd0;
                  state_nxt     = SEARCH;
               end
            end
         end

         ACTIVE: begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (byte_done) begin
               strobe_nxt = 1'b1;
               if (cand_is_comma) begin
                  clr_valid = 1'b1;
               end else begin
                  load_data = 1'b1;
               end
            end
         end

         default: begin
            state_nxt     = SEARCH;
            bit_cnt_nxt   = 3'd0;
            comma_cnt_nxt = 4'd0;
         end
      endcase
   end

   // Serial shift register: one bit per edge, MSB arrives first.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         sr <= 8'h00;
      end else begin
         sr <= cand;
      end
   end

   // Alignment state, bit phase and comma run length.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         state     <= SEARCH;
         bit_cnt   <= 3'd0;
         comma_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         comma_cnt <= comma_cnt_nxt;
      end
   end

   // Lock flag tracks the registered state so it rises on the final aligned comma.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         active_r <= 1'b0;
      end else begin
         active_r <= (state_nxt == ACTIVE);
      end
   end

   // Recovered byte and its qualifier; both hold between byte boundaries.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         data_out_r    <= 8'h00;
         valid_out_r   <= 1'b0;
         byte_strobe_r <= 1'b0;
      end else begin
         byte_strobe_r <= strobe_nxt;
         if (load_data) begin
            data_out_r  <= cand;
            valid_out_r <= 1'b1;
         end else if (clr_valid) begin
            valid_out_r <= 1'b0;
         end
      end
   end

   assign bus.data_out    = data_out_r;
   assign bus.valid_out   = valid_out_r;
   assign bus.active      = active_r;
   assign bus.byte_strobe = byte_strobe_r;

endmodule

// File: tb/tb_serial_to_par_rx.sv
// Directed bench for serial_to_par_rx: lock acquisition, data recovery,
// misaligned start, broken comma runs, mid-stream reset and false commas.
module tb_serial_to_par_rx;

   logic clk_8f;
   logic reset_L;
   int   checks;
   int   errors;

   logic [7:0] obs_data   [8];
   logic       obs_valid  [8];
   logic       obs_active [8];
   logic       obs_strobe [8];

   serial_to_par_rx_if bus ();

   serial_to_par_rx #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
      .clk_8f  (clk_8f),
      .reset_L (reset_L),
      .bus     (bus)
   );

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   // Called at a falling edge; drives one bit, samples outputs after the rising edge,
   // and returns at the next falling edge.
   task automatic send_bit(input logic b, input int idx);
      bus.data_in = b;
      @(posedge clk_8f);
      #1;
      obs_data[idx]   = bus.data_out;
      obs_valid[idx]  = bus.valid_out;
      obs_active[idx] = bus.active;
      obs_strobe[idx] = bus.byte_strobe;
      @(negedge clk_8f);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         send_bit(b[7-i], i);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_8f);
      reset_L     = 1'b0;
      bus.data_in = 1'b0;
      repeat (3) @(negedge clk_8f);
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      reset_L     = 1'b0;
      bus.data_in = 1'b1;
      repeat (3) @(negedge clk_8f);
      checks++;
      if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset data_out: got %h, expected 00", bus.data_out); end
      checks++;
      if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b, expected 0", bus.valid_out); end
      checks++;
      if (bus.active !== 1'b0) begin errors++; $display("FAIL reset active: got %b, expected 0", bus.active); end
      checks++;
      if (bus.byte_strobe !== 1'b0) begin errors++; $display("FAIL reset byte_strobe: got %b, expected 0", bus.byte_strobe); end
      reset_L = 1'b1;
   endtask

   task automatic test_lock();
      for (int n = 0; n < 4; n++) begin
         send_byte(8'hBC);
         for (int i = 0; i < 8; i++) begin
            logic exp_act;
            exp_act = (n == 3 && i == 7);
            checks++;
            if (obs_active[i] !== exp_act) begin
               errors++;
               $display("FAIL lock active byte%0d bit%0d: got %b, expected %b", n, i, obs_active[i], exp_act);
            end
            checks++;
            if (obs_valid[i] !== 1'b0 || obs_strobe[i] !== 1'b0) begin
               errors++;
               $display("FAIL lock valid/strobe byte%0d bit%0d: got %b/%b, expected 0/0", n, i, obs_valid[i], obs_strobe[i]);
            end
         end
      end
   endtask

   task automatic test_data();
      logic [7:0] bytes  [4] = '{8'hA5, 8'h3C, 8'hBC, 8'hFF};
      logic [7:0] exp_d  [4] = '{8'hA5, 8'h3C, 8'h3C, 8'hFF};
      logic       exp_v  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] prev_d;
      logic       prev_v;
      prev_d = 8'h00;
      prev_v = 1'b0;
      for (int n = 0; n < 4; n++) begin
         send_byte(bytes[n]);
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs_data[i] !== prev_d || obs_valid[i] !== prev_v || obs_strobe[i] !== 1'b0) begin
               errors++;
               $display("FAIL data hold byte%0d bit%0d: got %h/%b/%b, expected %h/%b/0",
                        n, i, obs_data[i], obs_valid[i], obs_strobe[i], prev_d, prev_v);
            end
         end
         checks++;
         if (obs_data[7] !== exp_d[n] || obs_valid[7] !== exp_v[n] || obs_strobe[7] !== 1'b1) begin
            errors++;
            $display("FAIL data boundary byte%0d: got %h/%b/%b, expected %h/%b/1",
                     n, obs_data[7], obs_valid[7], obs_strobe[7], exp_d[n], exp_v[n]);
         end
         prev_d = exp_d[n];
         prev_v = exp_v[n];
      end
   endtask

   task automatic test_offset();
      logic [2:0] junk;
      junk = 3'b110;
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(junk[2-i], i);
      for (int n = 0; n < 4; n++) begin
         send_byte(8'hBC);
         checks++;
         if (obs_active[7] !== (n == 3)) begin
            errors++;
            $display("FAIL offset active after comma%0d: got %b, expected %b", n, obs_active[7], (n == 3));
         end
      end
      send_byte(8'h11);
      checks++;
      if (obs_data[7] !== 8'h11 || obs_valid[7] !== 1'b1) begin
         errors++;
         $display("FAIL offset data: got %h/%b, expected 11/1", obs_data[7], obs_valid[7]);
      end
   endtask

   task automatic test_unlock();
      do_reset();
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'h00);
      checks++;
      if (obs_active[7] !== 1'b0 || obs_valid[7] !== 1'b0) begin
         errors++;
         $display("FAIL unlock after 00: got active %b valid %b, expected 0/0", obs_active[7], obs_valid[7]);
      end
      for (int n = 0; n < 4; n++) begin
         send_byte(8'hBC);
         for (int i = 0; i < 8; i++) begin
            logic exp_act;
            exp_act = (n == 3 && i == 7);
            checks++;
            if (obs_active[i] !== exp_act) begin
               errors++;
               $display("FAIL relock active comma%0d bit%0d: got %b, expected %b", n, i, obs_active[i], exp_act);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] partial;
      partial = 8'hA5;
      send_byte(8'h5A);
      checks++;
      if (obs_data[7] !== 8'h5A || obs_valid[7] !== 1'b1) begin
         errors++;
         $display("FAIL premid data: got %h/%b, expected 5A/1", obs_data[7], obs_valid[7]);
      end
      for (int i = 0; i < 4; i++) send_bit(partial[7-i], i);
      reset_L = 1'b0;
      #1;
      checks++;
      if (bus.data_out !== 8'h00 || bus.valid_out !== 1'b0 || bus.active !== 1'b0 || bus.byte_strobe !== 1'b0) begin
         errors++;
         $display("FAIL midreset outputs: got %h/%b/%b/%b, expected 00/0/0/0",
                  bus.data_out, bus.valid_out, bus.active, bus.byte_strobe);
      end
      @(negedge clk_8f);
      reset_L = 1'b1;
      for (int n = 0; n < 4; n++) begin
         send_byte(8'hBC);
         checks++;
         if (obs_active[7] !== (n == 3)) begin
            errors++;
            $display("FAIL midreset relock comma%0d: got %b, expected %b", n, obs_active[7], (n == 3));
         end
      end
   endtask

   task automatic test_back_to_back();
      send_byte(8'h5E);
      checks++;
      if (obs_data[7] !== 8'h5E || obs_valid[7] !== 1'b1 || obs_strobe[7] !== 1'b1) begin
         errors++;
         $display("FAIL b2b first: got %h/%b/%b, expected 5E/1/1", obs_data[7], obs_valid[7], obs_strobe[7]);
      end
      send_byte(8'hF0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (obs_data[i] !== 8'h5E || obs_strobe[i] !== 1'b0 || obs_active[i] !== 1'b1) begin
            errors++;
            $display("FAIL b2b hold bit%0d: got %h/%b/%b, expected 5E/0/1", i, obs_data[i], obs_strobe[i], obs_active[i]);
         end
      end
      checks++;
      if (obs_data[7] !== 8'hF0 || obs_valid[7] !== 1'b1 || obs_strobe[7] !== 1'b1) begin
         errors++;
         $display("FAIL b2b second: got %h/%b/%b, expected F0/1/1", obs_data[7], obs_valid[7], obs_strobe[7]);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset_L     = 1'b0;
      bus.data_in = 1'b0;
      test_reset();
      do_reset();
      test_lock();
      test_data();
      test_offset();
      test_unlock();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_to_par_rx.md
SERIAL_TO_PAR_RX -- requirements
Module: serial_to_par_rx

Interface
REQ-001 The block SHALL have a parameter COMMA, default 8'hBC: the idle/alignment symbol sent by the transmitter when no valid data is present.
REQ-002 The block SHALL have a parameter LOCK_COUNT, default 4: the number of consecutive aligned COMMA bytes required to declare lock (legal range 1..15).
REQ-003 The block SHALL have port clk_8f, input, 1 bit: the single clock, one serial bit per rising edge.
REQ-004 The block SHALL have port reset_L, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data_in, input, 1 bit: the serial lane bit, MSB of each byte first.
REQ-006 The block SHALL have port data_out, output, 8 bits: the last recovered non-COMMA byte.
REQ-007 The block SHALL have port valid_out, output, 1 bit: data_out holds a valid byte for the current byte period.
REQ-008 The block SHALL have port active, output, 1 bit: byte alignment is locked.
REQ-009 The block SHALL have port byte_strobe, output, 1 bit: one-cycle pulse on each aligned byte boundary while active.

Function
REQ-010 The block SHALL shift data_in into an 8-bit register each edge: next = {sr[6:0], data_in}; "candidate" denotes this next value.
REQ-011 The block SHALL implement three states: SEARCH, ALIGN, ACTIVE.
REQ-012 In SEARCH, the block SHALL compare the candidate to COMMA every cycle; on match it SHALL go to ALIGN, clear the 3-bit bit counter to 0, and set comma count = 1.
REQ-013 In ALIGN and ACTIVE, the bit counter SHALL increment modulo 8; a byte completes at the edge where the counter wraps 7->0, and the candidate at that edge is the received byte.
REQ-014 In ALIGN, at byte completion, a COMMA SHALL increment comma count, and reaching LOCK_COUNT SHALL go to ACTIVE.
REQ-015 In ALIGN, at byte completion, a non-COMMA byte SHALL return the block to SEARCH with comma count cleared; the same edge SHALL NOT be re-evaluated as a new SEARCH match.
REQ-016 If LOCK_COUNT == 1, the SEARCH match SHALL go directly to ACTIVE.
REQ-017 The active output SHALL be registered and be 1 exactly when the state is ACTIVE, asserting at the edge of the LOCK_COUNT-th aligned COMMA.
REQ-018 In ACTIVE, at byte completion, the block SHALL assert byte_strobe for one cycle.
REQ-019 In ACTIVE, at byte completion, a non-COMMA byte SHALL be registered to data_out with valid_out = 1.
REQ-020 In ACTIVE, at byte completion, a COMMA byte SHALL set valid_out = 0 and leave data_out unchanged.
REQ-021 Outputs SHALL hold between byte completions; latency SHALL be 0 cycles after the edge sampling a byte's last bit.
REQ-022 Once ACTIVE, the block SHALL stay ACTIVE until reset; mid-stream comma-like bit patterns at non-boundary offsets SHALL be ignored.
REQ-023 The block SHALL NOT assert valid_out or byte_strobe outside ACTIVE.
REQ-024 The block SHALL hold the comma count saturated at LOCK_COUNT; it SHALL NOT wrap.

Reset
REQ-025 While reset_L = 0, the block SHALL immediately force state SEARCH, shift register 8'h00, bit counter 0, comma count 0, data_out 8'h00, valid_out 0, active 0, byte_strobe 0.
REQ-026 Reset asserted mid-byte or while ACTIVE SHALL discard the partial byte and lock; after release the block SHALL re-acquire from SEARCH.
REQ-027 The first edge after reset_L rises SHALL sample data_in normally.

Verification
REQ-028 The bench SHALL drive four BC bytes MSB-first from bit 0 after reset -> active rises at the edge of bit 31; valid_out = 0; byte_strobe pulses only from then on.
REQ-029 The bench SHALL drive lock (4x BC), then bytes 8'hA5, 8'h3C, BC, 8'hFF -> data_out = A5 (valid 1), 3C (valid 1), 3C (valid 0), FF (valid 1), each updating exactly at a byte boundary and held 8 cycles.
REQ-030 The bench SHALL drive 3 junk bits, then 4x BC, then 8'h11 -> lock at the correct 3-bit offset and data_out = 8'h11 with valid_out = 1.
REQ-031 The bench SHALL drive BC, BC, 8'h00, then 4x BC -> no lock after the 8'h00 (return to SEARCH), then active = 1 at the end of the fourth subsequent BC.
REQ-032 The bench SHALL pulse reset_L low at bit 4 of a data byte while ACTIVE -> all outputs 0 immediately; re-lock requires 4 fresh BC bytes.
REQ-033 The bench SHALL drive, while ACTIVE, the data pair 8'h5E, 8'hF0 (containing BC across the boundary) -> data_out = 5E then F0, valid_out = 1, with no realignment.
